// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the 8-bit bus CPU sequencer: opcodes, control-bit
// positions, control-word constants and the T-state encoding.
package cpu_sequencer_pkg;

    localparam int CW_W = 15;
    typedef logic [CW_W-1:0] cw_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_STA = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JC  = 4'd5;
    localparam logic [3:0] OP_JZ  = 4'd6;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    // Bit positions inside the control word, MSB first.
    localparam int CB_CP   = 14;
    localparam int CB_EP   = 13;
    localparam int CB_LP   = 12;
    localparam int CB_NLMA = 11;
    localparam int CB_NLMD = 10;
    localparam int CB_NCE  = 9;
    localparam int CB_NLR  = 8;
    localparam int CB_NLI  = 7;
    localparam int CB_NEI  = 6;
    localparam int CB_NLA  = 5;
    localparam int CB_EA   = 4;
    localparam int CB_SUB  = 3;
    localparam int CB_EU   = 2;
    localparam int CB_NLB  = 1;
    localparam int CB_NLO  = 0;

    localparam cw_t CW_IDLE    = 15'h0FE3;
    localparam cw_t CW_FETCH0  = 15'h27E3;
    localparam cw_t CW_FETCH1  = 15'h4FE3;
    localparam cw_t CW_FETCH2  = 15'h0D63;
    localparam cw_t CW_IR_MAR  = 15'h07A3;
    localparam cw_t CW_LDA_T4  = 15'h0DC3;
    localparam cw_t CW_RAM_B   = 15'h0DE1;
    localparam cw_t CW_ADD_T5  = 15'h0FC7;
    localparam cw_t CW_SUB_T5  = 15'h0FCF;
    localparam cw_t CW_STA_T4  = 15'h0BF3;
    localparam cw_t CW_STA_T5  = 15'h0EE3;
    localparam cw_t CW_JMP     = 15'h1FA3;
    localparam cw_t CW_OUT     = 15'h0FF2;

    // T0..T5 encode as their own index so the T-state output is a direct read.
    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_WAIT = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    function automatic logic is_halt_op(input logic [3:0] op, input logic halt_on_undef);
        return (op == OP_HLT) || (halt_on_undef && (op >= 4'd7) && (op <= 4'd13));
    endfunction

    function automatic logic [2:0] tstate_of(input state_t s);
        case (s)
            ST_T0:   return 3'd0;
            ST_T1:   return 3'd1;
            ST_T2:   return 3'd2;
            ST_T3:   return 3'd3;
            ST_T4:   return 3'd4;
            ST_T5:   return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer_microrom.sv
// Combinational microcode ROM: (T-state, opcode, flags) -> control word and
// a flag marking the last T-state of the current instruction.
module cpu_microrom
    import cpu_sequencer_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       cf,
    input  logic       zf,
    output cw_t        control_word,
    output logic       last
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        control_word = CW_IDLE;
        last         = 1'b0;
        case (state)
            ST_T0: control_word = CW_FETCH0;
            ST_T1: control_word = CW_FETCH1;
            ST_T2: control_word = CW_FETCH2;
            ST_T3: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: control_word = CW_IR_MAR;
                    OP_JMP: begin
                        control_word = CW_JMP;
                        last         = 1'b1;
                    end
                    OP_JC: begin
                        if (cf) control_word = CW_JMP;
                        last = 1'b1;
                    end
                    OP_JZ: begin
                        if (zf) control_word = CW_JMP;
                        last = 1'b1;
                    end
                    OP_OUT: begin
                        control_word = CW_OUT;
                        last         = 1'b1;
                    end
                    default: last = 1'b1;   // HLT and opcodes 7-13 spend T3 idle
                endcase
            end
            ST_T4: begin
                case (opcode)
                    OP_LDA: begin
                        control_word = CW_LDA_T4;
                        last         = 1'b1;
                    end
                    OP_ADD, OP_SUB: control_word = CW_RAM_B;
                    OP_STA:         control_word = CW_STA_T4;
                    default:        last = 1'b1;
                endcase
            end
            ST_T5: begin
                // T5 always terminates, even for opcodes that never reach it.
                last = 1'b1;
                case (opcode)
                    OP_ADD:  control_word = CW_ADD_T5;
                    OP_SUB:  control_word = CW_SUB_T5;
                    OP_STA:  control_word = CW_STA_T5;
                    default: control_word = CW_IDLE;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// T-state sequencer for the 8-bit bus CPU: run/single-step gating, early
// instruction termination and a sticky halt around the microcode ROM.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        cf,
    input  logic        zf,
    input  logic        run,
    input  logic        step,
    output logic [14:0] control_word,
    output logic [2:0]  tstate,
    output logic        instr_done,
    output logic        halted
);

    state_t state;
    state_t state_next;
    logic   step_q;
    logic   step_edge;
    cw_t    rom_word;
    logic   rom_last;

    assign step_edge = step & ~step_q;

    cpu_microrom u_microrom (
        .state        (state),
        .opcode       (opcode),
        .cf           (cf),
        .zf           (zf),
        .control_word (rom_word),
        .last         (rom_last)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_WAIT;
            step_q <= 1'b0;
        end else begin
            state  <= state_next;
            step_q <= step;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT: if (run || step_edge) state_next = ST_T0;
            ST_T0:   state_next = ST_T1;
            ST_T1:   state_next = ST_T2;
            ST_T2:   state_next = ST_T3;
            ST_T3, ST_T4, ST_T5: begin
                if (rom_last) begin
                    if (is_halt_op(opcode, HALT_ON_UNDEF)) state_next = ST_HALT;
                    else                                   state_next = run ? ST_T0 : ST_WAIT;
                end else if (state == ST_T3) begin
                    state_next = ST_T4;
                end else begin
                    state_next = ST_T5;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_WAIT;
        endcase
    end

    // Reset masks the outputs immediately so no partial word reaches the datapath.
    always_comb begin
        control_word = rom_word;
        tstate       = tstate_of(state);
        instr_done   = rom_last;
        halted       = (state == ST_HALT);
        if (rst) begin
            control_word = CW_IDLE;
            tstate       = 3'd7;
            instr_done   = 1'b0;
            halted       = 1'b0;
        end
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Microcode sequencer for the 8-bit bus CPU. It steps a T-state machine: fetch in T0-T2, then an opcode-dependent execute phase in T3-T5. Each cycle it drives the 15-bit control word that gates the PC, MAR/RAM, IR, accumulator, ALU, B and output registers. It adds run/single-step gating, early instruction termination, conditional jumps on CF/ZF, and a sticky halt.

Parameters:
HALT_ON_UNDEF, 0, 1 = opcodes 7-13 behave as HLT; 0 = opcodes 7-13 behave as NOP.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
opcode  input  4  IR opcode; stable from T3 onward
cf  input  1  ALU carry flag (registered in ALU)
zf  input  1  ALU zero flag (registered in ALU)
run  input  1  level: 1 = free-run, 0 = single-step
step  input  1  single-step request; acts on its rising edge
control_word  output  15  {Cp,Ep,Lp,nLma,nLmd,nCE,nLr,nLi,nEi,nLa,Ea,sub,Eu,nLb,nLo}, bit 14 down to 0
tstate  output  3  current T-state 0-5; 7 in WAIT/HALT
instr_done  output  1  high during the last T-state of each instruction
halted  output  1  high in HALT

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- States: WAIT, T0, T1, T2, T3, T4, T5, HALT.
- Reset, sampled at clk edge: state=WAIT, step_q=0.
  - While rst=1: control_word=IDLE (0x0FE3), tstate=7, instr_done=0, halted=0.
- control_word, instr_done and tstate are combinational from (state, opcode, cf, zf). Datapath registers act on the edge that ends the T-state.
- step_edge = step & ~step_q; step_q is a register.
- WAIT: drives IDLE. Goes to T0 if run=1 or step_edge; otherwise stays.
- Fetch words:
  - T0 = 0x27E3 (Ep, MAR<-PC)
  - T1 = 0x4FE3 (Cp)
  - T2 = 0x0D63 (nCE, nLi)
- Execute words; an unlisted state drives IDLE; L marks the last state:
  - LDA 0: T3 0x07A3, T4 0x0DC3 L
  - ADD 1: T3 0x07A3, T4 0x0DE1, T5 0x0FC7 L
  - SUB 2: T3 0x07A3, T4 0x0DE1, T5 0x0FCF L
  - STA 3: T3 0x07A3, T4 0x0BF3, T5 0x0EE3 L
  - JMP 4: T3 0x1FA3 L
  - JC 5: T3 0x1FA3 if cf else IDLE, L
  - JZ 6: T3 0x1FA3 if zf else IDLE, L
  - OUT 14 (0xE): T3 0x0FF2 L
  - NOP 7-13: T3 IDLE L, or HLT behaviour if HALT_ON_UNDEF=1
  - HLT 15: T3 IDLE L; next state HALT
- After the last state: go to T0 if run=1, otherwise WAIT. A step_edge that occurs mid-instruction is ignored and not queued.
- Step mode: one step_edge executes exactly one full instruction.
- HALT: drives IDLE, halted=1, tstate=7. Ignores run and step; left only by rst.
- instr_done: high for exactly one cycle per instruction, in its L state.
- run dropping mid-instruction: the instruction completes, then the machine parks in WAIT.
- Reset mid-instruction: the next cycle is WAIT with IDLE; no partial word persists.
- At most one active-low RAM strobe (nLr, nLmd, nCE) is asserted in any cycle.

Decomposition:
- Shared package: opcode constants (OP_LDA..OP_HLT); control-bit index constants; control-word constants (CW_IDLE, CW_FETCH0..2, per-op execute words); state encoding.
- Sub-module cpu_microrom: combinational (state, opcode, cf, zf) -> {control_word, last}. The sequencer FSM and step edge detector stay in cpu_sequencer.

Test Plan:
- Reset: rst=1 for 2 cycles with run=1 -> control_word=0x0FE3, tstate=7. After release: WAIT for 1 cycle, then T0 drives 0x27E3, T1 0x4FE3, T2 0x0D63.
- run=1, opcode=1 (ADD) -> words 0x27E3, 0x4FE3, 0x0D63, 0x07A3, 0x0DE1, 0x0FC7; instr_done only on the 6th cycle; 7th cycle is T0.
- run=1, opcode=5 (JC) with cf=0 then cf=1 -> T3 word 0x0FE3 then 0x1FA3; both instructions take 4 cycles.
- run=0, a single step pulse, opcode=0 (LDA) -> exactly 5 active cycles ending in 0x0DC3, then WAIT. A second step pulse issued during T2 has no effect.
- opcode=15 (HLT) -> halted=1 from the cycle after T3, control_word=0x0FE3. Toggling run/step leaves it halted; rst=1 returns to WAIT.
- HALT_ON_UNDEF=1, opcode=9 -> halted. HALT_ON_UNDEF=0, opcode=9 -> 4-cycle NOP, then T0.
